if_id_stage: RTL and testbench
==============================

Name: if_id_stage

Overview:
- Instruction-fetch unit plus IF/ID pipeline register for the 16-bit RISC-Z core.
- Owns the PC and drives word-addressed instruction memory through a req/ready handshake.
- Latches each fetched instruction with its PC and slices out the immediate fields that feed the sign extender: In0 = 10-bit, In1 = 4-bit, In2 = 6-bit, In3 = 8-bit.
- The control unit uses id_opcode to select SignOp.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- PC_INC, 1, PC increment per accepted fetch (word-addressed memory).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hazard unit: freeze PC and IF/ID contents.
- redirect  input  1  branch/jump taken: load redirect_pc, flush IF/ID.
- redirect_pc  input  16  target PC.
- imem_req  output  1  fetch request.
- imem_addr  output  16  fetch address (current PC).
- imem_ready  input  1  memory response; imem_rdata is valid when imem_req & imem_ready.
- imem_rdata  input  16  fetched instruction.
- id_valid  output  1  IF/ID holds a real instruction.
- id_pc  output  16  PC of the IF/ID instruction.
- id_pc_plus1  output  16  id_pc + PC_INC, mod 2^16.
- id_instr  output  16  raw instruction.
- id_opcode  output  4  id_instr[15:12].
- id_imm10  output  10  id_instr[9:0], to sign_ext In0.
- id_imm4  output  4  id_instr[3:0], to sign_ext In1.
- id_imm6  output  6  id_instr[5:0], to sign_ext In2.
- id_imm8  output  8  id_instr[7:0], to sign_ext In3.

Behaviour:
- Reset (async, any time, including mid-fetch):
  - pc = RESET_PC; state = S_RST.
  - id_valid = 0; id_instr = 0; id_pc = 0.
  - imem_req = 0; any in-flight response is discarded.
- The field outputs are pure combinational slices of the id_instr register; id_pc_plus1 is combinational from id_pc.
- FSM states: S_RST, S_FETCH, S_REDIR.
  - S_RST: imem_req = 0 for exactly one cycle after reset release, then go to S_FETCH.
  - S_FETCH: imem_req = ~stall & ~redirect; imem_addr = pc.
  - S_REDIR: one bubble cycle after a redirect; imem_req = 0; then go to S_FETCH.
- Accept is defined as imem_req & imem_ready. A same-cycle (combinational) ready is legal, and a multi-cycle wait is legal.
- Priority: rst > redirect > stall > accept.
- redirect = 1 (any state):
  - pc <= redirect_pc; id_valid <= 0; next state = S_REDIR.
  - Redirect overrides stall.
- stall = 1, no redirect:
  - pc, id_* and state are held; imem_req = 0, so no accept can occur.
- Accept, no stall, no redirect:
  - id_instr <= imem_rdata; id_pc <= pc; id_valid <= 1; pc <= pc + PC_INC.
- S_FETCH, no accept, no stall, no redirect:
  - id_valid <= 0 (bubble); id_instr and id_pc hold their last values; pc holds.
- Latency: an instruction accepted in cycle N is visible on id_* in cycle N+1. Throughput is one instruction per cycle with an always-ready memory.
- PC wraps: 16'hFFFF + 1 -> 16'h0000. id_pc_plus1 wraps identically.
- Simultaneous stall and redirect: the redirect is taken and the flush happens. The stall has no effect on pc that cycle.
- imem_ready while imem_req = 0 is ignored.

Test Plan:
- Reset then free-run, imem_ready = 1, memory returns {4'h0, addr[11:0]}:
  - imem_req is low for 1 cycle after reset release, then high.
  - id_pc steps 0, 1, 2…; id_valid goes high 2 cycles after reset release.
- Field slicing, fetched word 16'h2EBA:
  - id_opcode = 4'h2; id_imm10 = 10'h2BA; id_imm8 = 8'hBA; id_imm6 = 6'h3A; id_imm4 = 4'hA.
- Fetched word 16'hAEBA:
  - id_imm10 = 10'h2BA; id_imm8 = 8'hBA; id_imm6 = 6'h3A; id_imm4 = 4'hA; opcode = 4'hA.
  - Sign bits are intact for downstream extension.
- Stall held for 3 cycles with id_pc = 5:
  - imem_req = 0; id_pc = 5 and id_instr are unchanged; pc stays 6; fetch resumes at 6 after stall drops.
- Redirect to 16'h0040 asserted together with stall and imem_ready:
  - Next cycle id_valid = 0, state is S_REDIR, imem_req = 0.
  - The following cycle imem_addr = 16'h0040; the next id_pc is 16'h0040.
- imem_ready low for 2 cycles at pc = 16'hFFFF:
  - id_valid = 0 during the wait.
  - Then id_pc = 16'hFFFF, id_pc_plus1 = 16'h0000, and the next imem_addr = 16'h0000.
- Assert rst mid-wait (imem_req = 1, imem_ready = 0):
  - All outputs clear immediately without a clock edge.
  - After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_id_stage_if.sv
// Instruction-memory fetch bus: request/address out, ready/data back.
// A beat is transferred in any cycle where req and ready are both high.
interface if_id_stage_if;
    logic        req;
    logic [15:0] addr;
    logic        ready;
    logic [15:0] rdata;

    modport master (output req, output addr, input ready, input rdata);
    modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/if_id_stage.sv
// Instruction fetch unit and IF/ID pipeline register for the 16-bit RISC-Z core.
// Owns the PC, fetches over a req/ready bus and exposes the immediate fields for sign extension.
module if_id_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          PC_INC   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [15:0]          redirect_pc,
    if_id_stage_if.master        imem,
    output logic                 id_valid,
    output logic [15:0]          id_pc,
    output logic [15:0]          id_pc_plus1,
    output logic [15:0]          id_instr,
    output logic [3:0]           id_opcode,
    output logic [9:0]           id_imm10,
    output logic [3:0]           id_imm4,
    output logic [5:0]           id_imm6,
    output logic [7:0]           id_imm8
);

    localparam logic [15:0] PC_STEP = 16'(PC_INC);

    typedef enum logic [1:0] {
        S_RST   = 2'd0,
        S_FETCH = 2'd1,
        S_REDIR = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic        id_valid_q, id_valid_d;
    logic [15:0] id_pc_q, id_pc_d;
    logic [15:0] id_instr_q, id_instr_d;
    logic        req;
    logic        accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_RST;
            pc_q       <= RESET_PC;
            id_valid_q <= 1'b0;
            id_pc_q    <= 16'h0000;
            id_instr_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_instr_q <= id_instr_d;
        end
    end

    // Request is suppressed by stall/redirect so that a held or flushed cycle can never accept.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        id_instr_d = id_instr_q;
        req        = (state_q == S_FETCH) && !stall && !redirect;
        accept     = req && imem.ready;

        if (redirect) begin
            pc_d       = redirect_pc;
            id_valid_d = 1'b0;
            state_d    = S_REDIR;
        end else if (!stall) begin
            case (state_q)
                S_RST, S_REDIR: begin
                    id_valid_d = 1'b0;
                    state_d    = S_FETCH;
                end
                S_FETCH: begin
                    if (accept) begin
                        id_instr_d = imem.rdata;
                        id_pc_d    = pc_q;
                        id_valid_d = 1'b1;
                        pc_d       = pc_q + PC_STEP;
                    end else begin
                        id_valid_d = 1'b0;
                    end
                end
                default: begin
                    id_valid_d = 1'b0;
                    state_d    = S_RST;
                end
            endcase
        end
    end

    assign imem.req    = req;
    assign imem.addr   = pc_q;

    assign id_valid    = id_valid_q;
    assign id_pc       = id_pc_q;
    assign id_pc_plus1 = id_pc_q + PC_STEP;
    assign id_instr    = id_instr_q;
    assign id_opcode   = id_instr_q[15:12];
    assign id_imm10    = id_instr_q[9:0];
    assign id_imm4     = id_instr_q[3:0];
    assign id_imm6     = id_instr_q[5:0];
    assign id_imm8     = id_instr_q[7:0];

endmodule

// File: tb/tb_if_id_stage.sv
// Directed plus randomized bench for if_id_stage against a behavioural fetch-pipeline model.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        id_valid;
    logic [15:0] id_pc, id_pc_plus1, id_instr;
    logic [3:0]  id_opcode, id_imm4;
    logic [9:0]  id_imm10;
    logic [5:0]  id_imm6;
    logic [7:0]  id_imm8;

    if_id_stage_if bus ();

    if_id_stage #(.RESET_PC(16'h0000), .PC_INC(1)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem(bus.master),
        .id_valid(id_valid), .id_pc(id_pc), .id_pc_plus1(id_pc_plus1),
        .id_instr(id_instr), .id_opcode(id_opcode), .id_imm10(id_imm10),
        .id_imm4(id_imm4), .id_imm6(id_imm6), .id_imm8(id_imm8)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Model: architectural PC, IF/ID contents, and bubble cycles still owed after reset/redirect.
    logic [15:0] m_pc;
    logic        m_valid;
    logic [15:0] m_idpc;
    logic [15:0] m_instr;
    int          m_bubble;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_pc = 16'h0000; m_valid = 1'b0; m_idpc = 16'h0000;
        m_instr = 16'h0000; m_bubble = 1;
    endtask

    task automatic chk_id(input string tag);
        chk({tag, ".valid"}, 32'(id_valid), 32'(m_valid));
        chk({tag, ".pc"}, 32'(id_pc), 32'(m_idpc));
        chk({tag, ".pc1"}, 32'(id_pc_plus1), 32'(16'(m_idpc + 16'd1)));
        chk({tag, ".instr"}, 32'(id_instr), 32'(m_instr));
        chk({tag, ".fields"}, {id_opcode, id_imm10, id_imm8, id_imm6, id_imm4},
            {m_instr[15:12], m_instr[9:0], m_instr[7:0], m_instr[5:0], m_instr[3:0]});
    endtask

    // One clock: apply inputs, check request side, clock, update model, check IF/ID side.
    task automatic cycle(input logic st, input logic rd, input logic [15:0] rpc,
                         input logic rdy, input logic [15:0] data);
        logic exp_req;
        stall = st; redirect = rd; redirect_pc = rpc;
        bus.ready = rdy; bus.rdata = data;
        #1;
        exp_req = (m_bubble == 0) && !st && !rd;
        chk("req", 32'(bus.req), 32'(exp_req));
        chk("addr", 32'(bus.addr), 32'(m_pc));
        @(posedge clk);
        if (rd) begin
            m_pc = rpc; m_valid = 1'b0; m_bubble = 1;
        end else if (!st) begin
            if (m_bubble > 0) begin
                m_bubble--; m_valid = 1'b0;
            end else if (rdy) begin
                m_instr = data; m_idpc = m_pc; m_valid = 1'b1; m_pc = m_pc + 16'd1;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
        chk_id("id");
    endtask

    function automatic logic [15:0] memword(input logic [15:0] a);
        return {4'h0, a[11:0]};
    endfunction

    initial begin
        logic [15:0] w;
        bus.ready = 1'b0; bus.rdata = 16'h0000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.req", 32'(bus.req), 32'd0);
        chk_id("rst");
        rst = 1'b0;

        // Free run; plant two field-test words at addresses 2 and 3.
        for (int i = 0; i < 40 && !(m_valid && m_idpc == 16'd5); i++) begin
            w = (m_pc == 16'd2) ? 16'h2EBA : (m_pc == 16'd3) ? 16'hAEBA : memword(m_pc);
            cycle(1'b0, 1'b0, 16'h0, 1'b1, w);
            if (m_valid && m_idpc == 16'd2) begin
                chk("f2EBA", {id_opcode, id_imm10, id_imm8, id_imm6, id_imm4},
                    {4'h2, 10'h2BA, 8'hBA, 6'h3A, 4'hA});
            end
            if (m_valid && m_idpc == 16'd3) begin
                chk("fAEBA", {id_opcode, id_imm10, id_imm8, id_imm6, id_imm4},
                    {4'hA, 10'h2BA, 8'hBA, 6'h3A, 4'hA});
            end
        end
        chk("reach5", 32'(id_pc), 32'd5);

        // Stall three cycles with ready high: nothing moves.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 16'h0, 1'b1, 16'hDEAD);
            chk("stall.pc", 32'(id_pc), 32'd5);
            chk("stall.addr", 32'(bus.addr), 32'd6);
        end
        chk("resume.addr", 32'(bus.addr), 32'd6);
        cycle(1'b0, 1'b0, 16'h0, 1'b1, memword(m_pc));
        chk("resume.idpc", 32'(id_pc), 32'd6);

        // Redirect together with stall and ready.
        cycle(1'b1, 1'b1, 16'h0040, 1'b1, 16'hBEEF);
        chk("redir.valid", 32'(id_valid), 32'd0);
        cycle(1'b0, 1'b0, 16'h0, 1'b1, 16'h1111);
        chk("bubble.valid", 32'(id_valid), 32'd0);
        chk("redir.addr", 32'(bus.addr), 32'h0040);
        cycle(1'b0, 1'b0, 16'h0, 1'b1, memword(m_pc));
        chk("redir.idpc", 32'(id_pc), 32'h0040);

        // Wrap: wait two cycles at 16'hFFFF, then accept.
        cycle(1'b0, 1'b1, 16'hFFFF, 1'b1, 16'h0);
        cycle(1'b0, 1'b0, 16'h0, 1'b1, 16'h0);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b0, 16'h0, 1'b0, 16'h7777);
            chk("wait.valid", 32'(id_valid), 32'd0);
        end
        cycle(1'b0, 1'b0, 16'h0, 1'b1, 16'h5A5A);
        chk("wrap.idpc", 32'(id_pc), 32'hFFFF);
        chk("wrap.pc1", 32'(id_pc_plus1), 32'h0000);
        chk("wrap.addr", 32'(bus.addr), 32'h0000);

        // Reset in the middle of a wait, without a clock edge.
        cycle(1'b0, 1'b0, 16'h0, 1'b1, 16'h1234);
        stall = 1'b0; redirect = 1'b0; bus.ready = 1'b0;
        #1;
        chk("prerst.req", 32'(bus.req), 32'd1);
        #1 rst = 1'b1;
        #1;
        model_reset();
        chk("arst.req", 32'(bus.req), 32'd0);
        chk("arst.addr", 32'(bus.addr), 32'd0);
        chk_id("arst");
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 16'h0, 1'b1, memword(m_pc));
        chk("restart.idpc", 32'(id_pc), 32'd2);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(3) == 0, $urandom_range(7) == 0, 16'($urandom),
                  $urandom_range(3) != 0, 16'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
